// File: rtl/sim_test_ctrl.sv
// sim_test_ctrl: run/verdict sequencer for ISA self-test runs of the soc.
// Holds the core in reset for a fixed interval, releases it, snoops the register-file
// write port for the test-protocol registers (NUM_REG test number, END_REG end flag,
// PASS_REG pass flag) and latches a sticky PASS/FAIL verdict, re-halting the core.
// Optional run-cycle timeout enabled by defining SIM_TEST_CTRL_TIMEOUT_EN.
// Ports:
//   clk_i          clock
//   rst_ni         asynchronous reset, active-low
//   start_i        launch a run (1-cycle pulse, honoured in IDLE and verdict states)
//   regs_we_i      snooped register-file write enable
//   regs_waddr_i   snooped register-file write address
//   regs_wdata_i   snooped register-file write data
//   cpu_hold_o     1 = core held in reset / halted
//   done_o         sticky: verdict reached
//   pass_o         sticky: test passed
//   fail_o         sticky: test failed (incl. timeout)
//   timeout_o      sticky: run hit TIMEOUT_CYC
//   fail_testnum_o low 32 bits of the test-number shadow captured at a failing verdict
//   cycle_cnt_o    cycles spent in RUN, saturating
//   state_o        FSM state encoding (debug)
module sim_test_ctrl #(
    parameter int DW          = 64,
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 32,
    parameter int TIMEOUT_CYC = 100000,
    parameter int NUM_REG     = 3,
    parameter int END_REG     = 26,
    parameter int PASS_REG    = 27
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             regs_we_i,
    input  logic [4:0]       regs_waddr_i,
    input  logic [DW-1:0]    regs_wdata_i,
    output logic             cpu_hold_o,
    output logic             done_o,
    output logic             pass_o,
    output logic             fail_o,
    output logic             timeout_o,
    output logic [31:0]      fail_testnum_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [2:0]       state_o
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HOLD = 3'd1,
        S_RUN  = 3'd2,
        S_PASS = 3'd3,
        S_FAIL = 3'd4,
        S_TOUT = 3'd5
    } state_e;

    localparam int          HOLD_N = HOLD_CYCLES < 1 ? 1 : HOLD_CYCLES;
    localparam logic [4:0]  NUM_A  = 5'(NUM_REG);
    localparam logic [4:0]  END_A  = 5'(END_REG);
    localparam logic [4:0]  PASS_A = 5'(PASS_REG);
    localparam logic [DW-1:0] ONE  = DW'(1);

    state_e             state_q, state_d;
    logic [31:0]        hold_q, hold_d;
    logic               cpu_hold_q, cpu_hold_d;
    logic               done_q, done_d, pass_q, pass_d, fail_q, fail_d, tout_q, tout_d;
    logic [31:0]        testnum_q, testnum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        num_q, num_d;
    logic               pflag_q, pflag_d;
    logic               wr, end_wr;

    // Writes to x0 never reach the register file, so they are never snooped.
    assign wr     = regs_we_i && regs_waddr_i != 5'd0;
    assign end_wr = wr && regs_waddr_i == END_A && regs_wdata_i == ONE;

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        cpu_hold_d = cpu_hold_q;
        done_d     = done_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        tout_d     = tout_q;
        testnum_d  = testnum_q;
        cnt_d      = cnt_q;
        num_d      = num_q;
        pflag_d    = pflag_q;
        case (state_q)
            S_IDLE, S_PASS, S_FAIL, S_TOUT: begin
                if (start_i) begin
                    state_d    = S_HOLD;
                    hold_d     = 32'(HOLD_N - 1);
                    cpu_hold_d = 1'b1;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    fail_d     = 1'b0;
                    tout_d     = 1'b0;
                    testnum_d  = '0;
                    cnt_d      = '0;
                    num_d      = '0;
                    pflag_d    = 1'b0;
                end
            end
            S_HOLD: begin
                if (hold_q == 32'd0) begin
                    state_d    = S_RUN;
                    cpu_hold_d = 1'b0;
                end else begin
                    hold_d = hold_q - 32'd1;
                end
            end
            S_RUN: begin
                cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
                if (wr && regs_waddr_i == NUM_A)
                    num_d = 32'(regs_wdata_i);
                if (wr && regs_waddr_i == PASS_A)
                    pflag_d = regs_wdata_i == ONE;
                // The verdict uses the pass flag as it stood before this edge.
                if (end_wr) begin
                    state_d    = pflag_q ? S_PASS : S_FAIL;
                    cpu_hold_d = 1'b1;
                    done_d     = 1'b1;
                    pass_d     = pflag_q;
                    fail_d     = !pflag_q;
                    testnum_d  = pflag_q ? 32'd0 : num_q;
                end
`ifdef SIM_TEST_CTRL_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d    = S_TOUT;
                    cpu_hold_d = 1'b1;
                    done_d     = 1'b1;
                    fail_d     = 1'b1;
                    tout_d     = 1'b1;
                    testnum_d  = num_q;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            hold_q     <= '0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            tout_q     <= 1'b0;
            testnum_q  <= '0;
            cnt_q      <= '0;
            num_q      <= '0;
            pflag_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            tout_q     <= tout_d;
            testnum_q  <= testnum_d;
            cnt_q      <= cnt_d;
            num_q      <= num_d;
            pflag_q    <= pflag_d;
        end
    end

    assign cpu_hold_o     = cpu_hold_q;
    assign done_o         = done_q;
    assign pass_o         = pass_q;
    assign fail_o         = fail_q;
    assign timeout_o      = tout_q;
    assign fail_testnum_o = testnum_q;
    assign cycle_cnt_o    = cnt_q;
    assign state_o        = state_q;
endmodule

// File: tb/tb_sim_test_ctrl.sv
// tb_sim_test_ctrl: randomized self-checking bench for sim_test_ctrl against a run-level model.
module tb_sim_test_ctrl;
    localparam int H  = 4;
    localparam int TO = 16;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [63:0] wdata = '0;
    logic        cpu_hold, done, pass, fail, timeout;
    logic [31:0] fail_testnum, cycle_cnt;
    logic [2:0]  state;

    int checks = 0, failures = 0;
    logic [31:0] m_num;
    bit          m_pf, m_run;
    int          m_cyc;

    sim_test_ctrl #(.DW(64), .HOLD_CYCLES(H), .CNT_W(32), .TIMEOUT_CYC(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .regs_we_i(we), .regs_waddr_i(waddr),
        .regs_wdata_i(wdata), .cpu_hold_o(cpu_hold), .done_o(done), .pass_o(pass), .fail_o(fail),
        .timeout_o(timeout), .fail_testnum_o(fail_testnum), .cycle_cnt_o(cycle_cnt), .state_o(state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        if (m_run) m_cyc++;
    endtask

    // One bus cycle on the snooped write port; the model tracks the shadows a run would hold.
    task automatic wr(input logic [4:0] a, input logic [63:0] d, input bit e);
        we = e; waddr = a; wdata = d;
        if (m_run && e && a == 5'd3) m_num = d[31:0];
        if (m_run && e && a == 5'd27) m_pf = (d == 64'd1);
        step();
        we = 1'b0;
    endtask

    task automatic launch();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (H) step();
        m_run = 1; m_cyc = 0; m_num = '0; m_pf = 0;
    endtask

    task automatic end_run();
        wr(5'd26, 64'd1, 1'b1);
        m_run = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({state, cpu_hold, done, pass, fail, timeout} !== {3'd0, 5'b10000}) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=%b", {state, cpu_hold, done, pass, fail, timeout}, {3'd0, 5'b10000});
        end
        checks++;
        if ({fail_testnum, cycle_cnt} !== 64'd0) begin
            failures++;
            $display("FAIL reset_counts got=%h exp=0", {fail_testnum, cycle_cnt});
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_hold();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < H; k++) begin
            checks++;
            if ({cpu_hold, state} !== {1'b1, 3'd1}) begin
                failures++;
                $display("FAIL hold_cycle%0d got=%b/%0d exp=1/1", k, cpu_hold, state);
            end
            step();
        end
        m_run = 1; m_cyc = 0; m_num = '0; m_pf = 0;
        checks++;
        if ({cpu_hold, state, cycle_cnt} !== {1'b0, 3'd2, 32'd0}) begin
            failures++;
            $display("FAIL hold_release got=%b/%0d/%0d exp=0/2/0", cpu_hold, state, cycle_cnt);
        end
        wr(5'd3, 64'd5, 1'b1);
        wr(5'd27, 64'd1, 1'b1);
        end_run();
    endtask

    task automatic test_pass();
        launch();
        wr(5'd3, 64'd5, 1'b1);
        wr(5'd27, 64'd1, 1'b1);
        step();
        end_run();
        checks++;
        if ({state, cpu_hold, done, pass, fail, timeout} !== {3'd3, 5'b11100}) begin
            failures++;
            $display("FAIL pass_verdict got=%b exp=%b", {state, cpu_hold, done, pass, fail, timeout}, {3'd3, 5'b11100});
        end
        checks++;
        if ({fail_testnum, cycle_cnt} !== {32'd0, 32'(m_cyc)}) begin
            failures++;
            $display("FAIL pass_counts got=%0d/%0d exp=0/%0d", fail_testnum, cycle_cnt, m_cyc);
        end
    endtask

    task automatic test_fail();
        launch();
        wr(5'd3, 64'd7, 1'b1);
        wr(5'd27, 64'd0, 1'b1);
        wr(5'd26, 64'd2, 1'b1);
        wr(5'd26, 64'h1_0000_0001, 1'b1);
        checks++;
        if ({state, done} !== {3'd2, 1'b0}) begin
            failures++;
            $display("FAIL end_non1_ignored got=%0d/%b exp=2/0", state, done);
        end
        end_run();
        checks++;
        if ({state, cpu_hold, done, pass, fail, timeout, fail_testnum} !== {3'd4, 5'b11010, 32'd7}) begin
            failures++;
            $display("FAIL fail_verdict got=%0d/%b/%0d exp=4/11010/7", state, {cpu_hold, done, pass, fail, timeout}, fail_testnum);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            logic [31:0] sv_num, sv_cnt;
            logic [2:0]  sv_state;
            launch();
            if (r == 3) begin
                start = 1'b1;
                step();
                start = 1'b0;
                checks++;
                if ({state, cpu_hold} !== {3'd2, 1'b0}) begin
                    failures++;
                    $display("FAIL start_in_run got=%0d/%b exp=2/0", state, cpu_hold);
                end
            end
            for (int n = $urandom_range(2, 10); n > 0; n--) begin
                int          sel;
                logic [4:0]  a;
                logic [63:0] d;
                sel = $urandom_range(0, 5);
                d = {$urandom, $urandom};
                a = sel == 0 ? 5'd3 : sel == 1 ? 5'd27 : sel == 2 ? 5'd26 : sel == 3 ? 5'd0 : 5'($urandom_range(0, 31));
                if (sel == 2) d = d | 64'h2;
                if (sel == 4 && a == 5'd26) a = 5'd25;
                if (sel == 5) begin a = 5'd27; d = 64'd1; end
                if (sel == 1 && $urandom_range(0, 1) == 1) d = 64'd1;
                wr(a, d, $urandom_range(0, 3) != 0);
            end
            end_run();
            checks++;
            if ({state, cpu_hold, done, pass, fail, timeout} !== {m_pf ? 3'd3 : 3'd4, 1'b1, 1'b1, m_pf, !m_pf, 1'b0}) begin
                failures++;
                $display("FAIL rand%0d_verdict got=%0d/%b exp_pass=%b", r, state, {cpu_hold, done, pass, fail, timeout}, m_pf);
            end
            checks++;
            if ({fail_testnum, cycle_cnt} !== {m_pf ? 32'd0 : m_num, 32'(m_cyc)}) begin
                failures++;
                $display("FAIL rand%0d_counts got=%h/%0d exp=%h/%0d", r, fail_testnum, cycle_cnt, m_pf ? 32'd0 : m_num, m_cyc);
            end
            sv_num = fail_testnum; sv_cnt = cycle_cnt; sv_state = state;
            wr(5'd3, {$urandom, $urandom}, 1'b1);
            wr(5'd27, 64'd1, 1'b1);
            wr(5'd26, 64'd1, 1'b1);
            checks++;
            if ({state, fail_testnum, cycle_cnt, cpu_hold} !== {m_pf ? 3'd3 : 3'd4, m_pf ? 32'd0 : m_num, 32'(m_cyc), 1'b1}) begin
                failures++;
                $display("FAIL rand%0d_frozen got=%0d/%h/%0d exp_from=%0d/%h/%0d", r, state, fail_testnum, cycle_cnt, sv_state, sv_num, sv_cnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        launch();
        wr(5'd27, 64'd1, 1'b1);
        end_run();
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({state, cpu_hold, done, pass, fail, timeout, fail_testnum, cycle_cnt} !== {3'd1, 5'b10000, 64'd0}) begin
            failures++;
            $display("FAIL rerun_clear got=%0d/%b/%0d/%0d exp=1/10000/0/0", state, {cpu_hold, done, pass, fail, timeout}, fail_testnum, cycle_cnt);
        end
        repeat (H) step();
        m_run = 1; m_cyc = 0; m_num = '0; m_pf = 0;
        wr(5'd3, 64'd9, 1'b1);
        end_run();
        checks++;
        if ({state, pass, fail, fail_testnum, cycle_cnt} !== {3'd4, 2'b01, 32'd9, 32'(m_cyc)}) begin
            failures++;
            $display("FAIL rerun_verdict got=%0d/%b%b/%0d/%0d exp=4/01/9/%0d", state, pass, fail, fail_testnum, cycle_cnt, m_cyc);
        end
    endtask

    task automatic test_timeout();
`ifdef SIM_TEST_CTRL_TIMEOUT_EN
        launch();
        wr(5'd3, 64'($urandom), 1'b1);
        repeat (TO - 2) step();
        checks++;
        if ({state, timeout, cycle_cnt} !== {3'd2, 1'b0, 32'(TO - 1)}) begin
            failures++;
            $display("FAIL tout_before got=%0d/%b/%0d exp=2/0/%0d", state, timeout, cycle_cnt, TO - 1);
        end
        step();
        m_run = 0;
        checks++;
        if ({state, cpu_hold, done, pass, fail, timeout, fail_testnum, cycle_cnt} !== {3'd5, 5'b11011, m_num, 32'(TO)}) begin
            failures++;
            $display("FAIL tout_verdict got=%0d/%b/%h/%0d exp=5/11011/%h/%0d", state, {cpu_hold, done, pass, fail, timeout}, fail_testnum, cycle_cnt, m_num, TO);
        end
        launch();
        wr(5'd27, 64'd1, 1'b1);
        repeat (TO - 2) step();
        end_run();
        checks++;
        if ({state, pass, fail, timeout, cycle_cnt} !== {3'd3, 3'b100, 32'(TO)}) begin
            failures++;
            $display("FAIL tout_race got=%0d/%b/%0d exp=3/100/%0d", state, {pass, fail, timeout}, cycle_cnt, TO);
        end
`else
        launch();
        repeat (3 * TO) step();
        checks++;
        if ({state, timeout, done, cycle_cnt} !== {3'd2, 2'b00, 32'(m_cyc)}) begin
            failures++;
            $display("FAIL no_timeout got=%0d/%b%b/%0d exp=2/00/%0d", state, timeout, done, cycle_cnt, m_cyc);
        end
        end_run();
`endif
    endtask

    task automatic test_reset_mid_run();
        launch();
        wr(5'd27, 64'd1, 1'b1);
        repeat (3) step();
        #2 rst_n = 1'b0;
        #1;
        m_run = 0;
        checks++;
        if ({state, cpu_hold, done, pass, fail, cycle_cnt} !== {3'd0, 4'b1000, 32'd0}) begin
            failures++;
            $display("FAIL reset_mid_run got=%0d/%b/%0d exp=0/1000/0", state, {cpu_hold, done, pass, fail}, cycle_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if ({state, cpu_hold} !== {3'd0, 1'b1}) begin
            failures++;
            $display("FAIL reset_stays_idle got=%0d/%b exp=0/1", state, cpu_hold);
        end
        launch();
        end_run();
        checks++;
        if ({state, fail, fail_testnum} !== {3'd4, 1'b1, 32'd0}) begin
            failures++;
            $display("FAIL post_reset_shadow got=%0d/%b/%h exp=4/1/0", state, fail, fail_testnum);
        end
    endtask

    initial begin
        m_run = 0; m_cyc = 0; m_num = '0; m_pf = 0;
        test_reset();
        test_hold();
        test_pass();
        test_fail();
        test_random();
        test_back_to_back();
        test_timeout();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
